// File: rtl/reg_arb_pkg.sv
// Shared state encoding and round-robin helper for the register-port arbiter.
package reg_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT_RD = 2'b10
    } state_t;

    // Request bits above NUM_REQ are zero, so wrapping at MAX_REQ behaves like wrapping at NUM_REQ.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [MAX_REQ-1:0] grant;
        logic [PTR_W-1:0]   idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over the request vector; the pointer moves past the owner on advance.
module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               i_clk_apb,
    input  logic               i_rstn_apb,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] owner,
    input  logic               advance,
    output logic [NUM_REQ-1:0] pick
);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner_idx;
    logic [MAX_REQ-1:0] pick_full;
    logic               pick_unused;

    assign pick_full   = rr_pick(MAX_REQ'(req), ptr);
    assign pick        = pick_full[NUM_REQ-1:0];
    assign pick_unused = ^pick_full;

    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner[k]) owner_idx = PTR_W'(k);
        end
    end

    always_ff @(posedge i_clk_apb) begin
        if (!i_rstn_apb) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares one register-access target port between NUM_REQ requesters, one transaction at a time,
// with read-data routing back to the owner and a bounded read wait.
module reg_port_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                          i_clk_apb,
    input  logic                          i_rstn_apb,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_req_rd_valid,
    output logic                          o_req_rd_err,
    output logic [DATA_WIDTH-1:0]         o_req_rd_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ADDR_WIDTH-1:0]         o_addr,
    output logic                          o_rd0_wr1,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    input  logic                          i_rd_valid,
    input  logic [DATA_WIDTH-1:0]         i_rd_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        rd_cnt;
    logic [NUM_REQ-1:0]      pick;
    logic                    load;
    logic                    advance;
    logic                    clr_cnt;
    logic                    inc_cnt;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_rd0_wr1;
    logic [DATA_WIDTH-1:0]   sel_wr_data;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .i_clk_apb (i_clk_apb),
        .i_rstn_apb(i_rstn_apb),
        .req       (i_req_valid),
        .owner     (o_grant),
        .advance   (advance),
        .pick      (pick)
    );

    always_comb begin
        sel_addr    = '0;
        sel_rd0_wr1 = 1'b0;
        sel_wr_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick[k]) begin
                sel_addr    = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_rd0_wr1 = i_req_rd0_wr1[k];
                sel_wr_data = i_req_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk_apb) begin
        if (!i_rstn_apb) state <= IDLE;
        else             state <= state_nxt;
    end

    // Completion pulses are combinational so the requester sees them in the accepting cycle.
    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        advance        = 1'b0;
        clr_cnt        = 1'b0;
        inc_cnt        = 1'b0;
        o_req_ready    = '0;
        o_req_rd_valid = '0;
        o_req_rd_err   = 1'b0;
        o_req_rd_data  = '0;
        case (state)
            IDLE: begin
                if (|i_req_valid) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (i_ready) begin
                    o_req_ready = o_grant;
                    if (o_rd0_wr1) begin
                        advance   = 1'b1;
                        state_nxt = IDLE;
                    end else if (i_rd_valid) begin
                        o_req_rd_valid = o_grant;
                        o_req_rd_data  = i_rd_data;
                        advance        = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        clr_cnt   = 1'b1;
                        state_nxt = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (i_rd_valid) begin
                    o_req_rd_valid = o_grant;
                    o_req_rd_data  = i_rd_data;
                    advance        = 1'b1;
                    state_nxt      = IDLE;
                end else if (rd_cnt == CNT_LAST) begin
                    o_req_rd_valid = o_grant;
                    o_req_rd_err   = 1'b1;
                    advance        = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Target fields are captured once at grant and ignore later requester changes.
    always_ff @(posedge i_clk_apb) begin
        if (!i_rstn_apb) begin
            rd_cnt    <= '0;
            o_valid   <= 1'b0;
            o_addr    <= '0;
            o_rd0_wr1 <= 1'b0;
            o_wr_data <= '0;
            o_grant   <= '0;
        end else begin
            if (load) begin
                o_valid   <= 1'b1;
                o_grant   <= pick;
                o_addr    <= sel_addr;
                o_rd0_wr1 <= sel_rd0_wr1;
                o_wr_data <= sel_wr_data;
            end else if (state == ISSUE && i_ready) begin
                o_valid <= 1'b0;
            end
            if (advance) o_grant <= '0;
            if (clr_cnt)      rd_cnt <= '0;
            else if (inc_cnt) rd_cnt <= rd_cnt + CNT_W'(1);
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed vector table, corner-case sequences, then random traffic vs a transaction model.
module tb_reg_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_rw;
    logic [N*DW-1:0] req_wd;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_rdv;
    logic            rd_err;
    logic [DW-1:0]   rdata;
    logic            tvalid;
    logic            tready;
    logic [AW-1:0]   taddr;
    logic            trw;
    logic [DW-1:0]   twd;
    logic            trdv;
    logic [DW-1:0]   trdata;
    logic [N-1:0]    grant;
    logic            busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)
    ) dut (
        .i_clk_apb     (clk),
        .i_rstn_apb    (rstn),
        .i_req_valid   (req_valid),
        .i_req_addr    (req_addr),
        .i_req_rd0_wr1 (req_rw),
        .i_req_wr_data (req_wd),
        .o_req_ready   (req_ready),
        .o_req_rd_valid(req_rdv),
        .o_req_rd_err  (rd_err),
        .o_req_rd_data (rdata),
        .o_valid       (tvalid),
        .i_ready       (tready),
        .o_addr        (taddr),
        .o_rd0_wr1     (trw),
        .o_wr_data     (twd),
        .i_rd_valid    (trdv),
        .i_rd_data     (trdata),
        .o_grant       (grant),
        .o_busy        (busy)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  rw;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic        rdy;
        logic        rdv;
        logic [31:0] rdat;
        logic        evalid;
        logic [1:0]  egrant;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic        erw;
        logic [1:0]  eready;
        logic [1:0]  erdv;
        logic        eerr;
        logic [31:0] erdat;
        logic        ebusy;
    } vec_t;

    vec_t vecs[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rw,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic rdy, input logic rdv, input logic [31:0] rd);
        req_valid = v;
        req_rw    = rw;
        req_addr  = {a1, a0};
        req_wd    = {d1, d0};
        tready    = rdy;
        trdv      = rdv;
        trdata    = rd;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [1:0]  rrSeq[4];
    int          nGrant;
    logic [1:0]  rv;
    logic [1:0]  rrw;
    logic [31:0] ra[2];
    logic [31:0] rdd[2];
    logic        rRdy;
    logic        rRdv;
    logic [31:0] rRdat;
    int          mOwner;
    int          mPtr;
    int          mWait;
    int          pk;
    bit          mAcc;
    bit          mRw;
    bit          done;
    logic [31:0] mAddr;
    logic [31:0] mWd;
    logic [1:0]  eGrant;
    logic [1:0]  eReady;
    logic [1:0]  eRdv;
    logic        eErr;
    logic [31:0] eRdat;

    initial begin
        vecs[0]  = '{2'b01, 2'b01, 32'h10, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{2'b01, 2'b01, 32'h10, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,
                     1'b1, 2'b01, 32'h10, 32'hA5A5_0001, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1};
        vecs[2]  = vecs[1];
        vecs[3]  = '{2'b01, 2'b01, 32'h10, 32'h0, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,
                     1'b1, 2'b01, 32'h10, 32'hA5A5_0001, 1'b1, 2'b01, 2'b00, 1'b0, 32'h0, 1'b1};
        vecs[4]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 2'b10, 32'h20, 32'h0, 1'b0, 2'b10, 2'b00, 1'b0, 32'h0, 1'b1};
        vecs[7]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b1};
        vecs[8]  = vecs[7];
        vecs[9]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D,
                     1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b1};
        vecs[10] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0BAD,
                     1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};

        rstn = 1'b0;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        tick;
        tick;
        #2;
        checkOutput("reset_valid", 64'(tvalid), 64'd0);
        checkOutput("reset_grant", 64'(grant), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_addr", 64'(taddr), 64'd0);
        checkOutput("reset_rdv", 64'(req_rdv), 64'd0);
        rstn = 1'b1;
        tick;

        // Single write by req0, then routed read by req1.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].rw, vecs[i].a0, vecs[i].a1, vecs[i].d0, 32'h0,
                          vecs[i].rdy, vecs[i].rdv, vecs[i].rdat);
            #2;
            checkOutput($sformatf("vec%0d_valid", i), 64'(tvalid), 64'(vecs[i].evalid));
            checkOutput($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].egrant));
            checkOutput($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].eready));
            checkOutput($sformatf("vec%0d_rdv", i), 64'(req_rdv), 64'(vecs[i].erdv));
            checkOutput($sformatf("vec%0d_err", i), 64'(rd_err), 64'(vecs[i].eerr));
            checkOutput($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].erdat));
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].ebusy));
            if (vecs[i].evalid) begin
                checkOutput($sformatf("vec%0d_addr", i), 64'(taddr), 64'(vecs[i].eaddr));
                checkOutput($sformatf("vec%0d_wdata", i), 64'(twd), 64'(vecs[i].ewd));
                checkOutput($sformatf("vec%0d_rw", i), 64'(trw), 64'(vecs[i].erw));
            end
            tick;
        end

        // Fairness with both requesters continuously writing.
        for (int i = 0; i < 4; i++) rrSeq[i] = 2'b00;
        nGrant = 0;
        applyStimulus(2'b11, 2'b11, 32'h100, 32'h104, 32'h1, 32'h2, 1'b1, 1'b0, 0);
        for (int c = 0; c < 20 && nGrant < 4; c++) begin
            #2;
            if (req_ready != 2'b00) begin
                rrSeq[nGrant] = req_ready;
                nGrant++;
            end
            tick;
        end
        checkOutput("rr_count", 64'(nGrant), 64'd4);
        checkOutput("rr_grant0", 64'(rrSeq[0]), 64'h1);
        checkOutput("rr_grant1", 64'(rrSeq[1]), 64'h2);
        checkOutput("rr_grant2", 64'(rrSeq[2]), 64'h1);
        checkOutput("rr_grant3", 64'(rrSeq[3]), 64'h2);

        // Read accepted and answered in the same cycle.
        applyStimulus(2'b01, 2'b00, 32'h30, 0, 0, 0, 1'b0, 1'b0, 0);
        #2;
        checkOutput("same_idle_busy", 64'(busy), 64'd0);
        tick;
        applyStimulus(2'b01, 2'b00, 32'h30, 0, 0, 0, 1'b1, 1'b1, 32'h1234_5678);
        #2;
        checkOutput("same_addr", 64'(taddr), 64'h30);
        checkOutput("same_ready", 64'(req_ready), 64'h1);
        checkOutput("same_rdv", 64'(req_rdv), 64'h1);
        checkOutput("same_rdata", 64'(rdata), 64'h1234_5678);
        checkOutput("same_err", 64'(rd_err), 64'd0);
        tick;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        #2;
        checkOutput("same_after_busy", 64'(busy), 64'd0);
        tick;

        // Read timeout on req1, late data ignored, next request served.
        applyStimulus(2'b10, 2'b00, 0, 32'h40, 0, 0, 1'b0, 1'b0, 0);
        tick;
        applyStimulus(2'b10, 2'b00, 0, 32'h40, 0, 0, 1'b1, 1'b0, 0);
        #2;
        checkOutput("to_grant", 64'(grant), 64'h2);
        checkOutput("to_ready", 64'(req_ready), 64'h2);
        tick;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        for (int w = 1; w <= 4; w++) begin
            #2;
            checkOutput($sformatf("to_wait%0d_rdv", w), 64'(req_rdv), (w == 4) ? 64'h2 : 64'h0);
            checkOutput($sformatf("to_wait%0d_err", w), 64'(rd_err), (w == 4) ? 64'h1 : 64'h0);
            checkOutput($sformatf("to_wait%0d_rdata", w), 64'(rdata), 64'h0);
            tick;
        end
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 32'h55);
        #2;
        checkOutput("to_late_rdv", 64'(req_rdv), 64'h0);
        checkOutput("to_late_busy", 64'(busy), 64'h0);
        tick;
        applyStimulus(2'b01, 2'b01, 32'h50, 0, 32'h77, 0, 1'b1, 1'b0, 0);
        #2;
        tick;
        #2;
        checkOutput("to_next_grant", 64'(grant), 64'h1);
        checkOutput("to_next_ready", 64'(req_ready), 64'h1);
        checkOutput("to_next_addr", 64'(taddr), 64'h50);
        tick;

        // Reset during a read wait; pointer must restart at requester 0.
        applyStimulus(2'b10, 2'b00, 0, 32'h60, 0, 0, 1'b1, 1'b0, 0);
        tick;
        tick;
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        #2;
        checkOutput("rst_wait_busy", 64'(busy), 64'h1);
        rstn = 1'b0;
        tick;
        #2;
        checkOutput("rst_valid", 64'(tvalid), 64'h0);
        checkOutput("rst_grant", 64'(grant), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_rdv", 64'(req_rdv), 64'h0);
        rstn = 1'b1;
        tick;
        applyStimulus(2'b11, 2'b11, 32'h70, 32'h74, 0, 0, 1'b0, 1'b1, 32'h99);
        #2;
        checkOutput("rst_idle_rdv", 64'(req_rdv), 64'h0);
        tick;
        applyStimulus(2'b11, 2'b11, 32'h70, 32'h74, 0, 0, 1'b1, 1'b0, 0);
        #2;
        checkOutput("rst_ptr_grant", 64'(grant), 64'h1);
        checkOutput("rst_ptr_ready", 64'(req_ready), 64'h1);
        tick;

        // Random traffic against a transaction-level model.
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        rstn = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
        rv = 2'b00;
        rrw = 2'b00;
        for (int k = 0; k < 2; k++) begin
            ra[k]  = 32'h0;
            rdd[k] = 32'h0;
        end
        mOwner = -1;
        mPtr   = 0;
        mWait  = 0;
        mAcc   = 1'b0;
        mRw    = 1'b0;
        mAddr  = 32'h0;
        mWd    = 32'h0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!rv[k] && $urandom_range(0, 2) == 0) begin
                    rv[k]  = 1'b1;
                    rrw[k] = 1'($urandom_range(0, 1));
                    ra[k]  = $urandom;
                    rdd[k] = $urandom;
                end
            end
            rRdy  = 1'($urandom_range(0, 1));
            rRdv  = ($urandom_range(0, 3) == 0);
            rRdat = $urandom;
            applyStimulus(rv, rrw, ra[0], ra[1], rdd[0], rdd[1], rRdy, rRdv, rRdat);
            #2;
            eGrant = (mOwner >= 0) ? 2'(1 << mOwner) : 2'b00;
            eReady = 2'b00;
            eRdv   = 2'b00;
            eErr   = 1'b0;
            eRdat  = 32'h0;
            done   = 1'b0;
            if (mOwner >= 0 && !mAcc && rRdy) begin
                eReady = eGrant;
                if (mRw) begin
                    done = 1'b1;
                end else if (rRdv) begin
                    eRdv  = eGrant;
                    eRdat = rRdat;
                    done  = 1'b1;
                end
            end else if (mOwner >= 0 && mAcc) begin
                if (rRdv) begin
                    eRdv  = eGrant;
                    eRdat = rRdat;
                    done  = 1'b1;
                end else if (mWait == TO - 1) begin
                    eRdv = eGrant;
                    eErr = 1'b1;
                    done = 1'b1;
                end
            end
            checkOutput("rnd_valid", 64'(tvalid), 64'(mOwner >= 0 && !mAcc));
            checkOutput("rnd_grant", 64'(grant), 64'(eGrant));
            checkOutput("rnd_busy", 64'(busy), 64'(mOwner >= 0));
            checkOutput("rnd_ready", 64'(req_ready), 64'(eReady));
            checkOutput("rnd_rdv", 64'(req_rdv), 64'(eRdv));
            checkOutput("rnd_err", 64'(rd_err), 64'(eErr));
            checkOutput("rnd_rdata", 64'(rdata), 64'(eRdat));
            if (mOwner >= 0 && !mAcc) begin
                checkOutput("rnd_addr", 64'(taddr), 64'(mAddr));
                checkOutput("rnd_rw", 64'(trw), 64'(mRw));
                checkOutput("rnd_wdata", 64'(twd), 64'(mWd));
            end
            // Advance the model across the coming clock edge.
            if (mOwner < 0) begin
                if (rv != 2'b00) begin
                    pk = -1;
                    for (int i = 0; i < 2; i++) begin
                        if (pk < 0 && rv[(mPtr + i) % 2]) pk = (mPtr + i) % 2;
                    end
                    mOwner = pk;
                    mAddr  = ra[pk];
                    mRw    = rrw[pk];
                    mWd    = rdd[pk];
                    mAcc   = 1'b0;
                end
            end else if (done) begin
                mPtr   = (mOwner + 1) % 2;
                mOwner = -1;
                mAcc   = 1'b0;
            end else if (!mAcc && rRdy) begin
                mAcc  = 1'b1;
                mWait = 0;
            end else if (mAcc) begin
                mWait++;
            end
            for (int k = 0; k < 2; k++) begin
                if (eReady[k]) rv[k] = 1'b0;
            end
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
